// File: rtl/pci_master_burst_engine.sv
// PCI initiator back-end: buffered multi-beat burst master with retry/disconnect reissue.
// Write and read data are staged in FIFO_DEPTH-entry FIFOs; space/data is reserved at command accept.
module pci_master_burst_engine #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned LEN_W      = 5,
  parameter int unsigned RETRY_MAX  = 15,
  parameter bit          USE_MRM    = 1'b1
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [31:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [31:0]      wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [31:0]      rd_data,
  output logic             done,
  output logic             err,
  output logic             dead,
  input  logic [31:0]      adio_out,
  output logic [31:0]      adio_in,
  input  logic             m_data,
  input  logic             m_data_vld,
  input  logic             m_addr_n,
  input  logic [39:0]      csr,
  output logic             request,
  output logic             requesthold,
  output logic             complete,
  output logic             m_ready,
  output logic             m_wrdn,
  output logic [3:0]       m_cbe
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned RW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_XFER, S_RTY, S_DONE, S_ABORT, S_DEAD
  } state_t;

  state_t           state;
  logic [31:0]      cur_addr;
  logic [LEN_W-1:0] remaining;
  logic [LEN_W-1:0] eff_len;
  logic [RW-1:0]    rtry_cnt;
  logic             wr_q;
  logic             got_beat;
  logic             m_dataq;
  logic             m_data_fell;
  logic             fatal;
  logic             beat;
  logic             drive_bus;

  logic [31:0]      wr_mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_wp, wr_rp;
  logic [CW-1:0]    wr_count;
  logic             wr_push, wr_pop;

  logic [31:0]      rd_mem [FIFO_DEPTH];
  logic [AW-1:0]    rd_wp, rd_rp;
  logic [CW-1:0]    rd_count;
  logic             rd_push, rd_pop;

  logic             unused_csr;

  assign unused_csr  = ^csr[37:0];
  assign eff_len     = (cmd_len == '0) ? LEN_W'(1) : cmd_len;
  assign m_data_fell = ~m_data & m_dataq;
  assign beat        = (state == S_XFER) && m_data_vld && (remaining != '0);

  assign wr_ready = (wr_count != CW'(FIFO_DEPTH));
  assign wr_push  = wr_valid & wr_ready;
  assign wr_pop   = beat & wr_q;

  assign rd_valid = (rd_count != '0);
  assign rd_pop   = rd_ready & rd_valid;
  assign rd_push  = beat & ~wr_q;
  assign rd_data  = rd_mem[rd_rp];

  assign requesthold = 1'b0;
  assign m_wrdn      = wr_q;
  assign drive_bus   = (state == S_REQ) || (state == S_XFER);

  // Accept only when the whole burst is already buffered (write) or has room (read),
  // so the data path never stalls or overflows once the core starts moving beats.
  always_comb begin
    cmd_ready = 1'b0;
    if (state == S_IDLE) begin
      if (cmd_write) cmd_ready = (32'(wr_count) >= 32'(eff_len));
      else           cmd_ready = ((32'(FIFO_DEPTH) - 32'(rd_count)) >= 32'(eff_len));
    end
  end

  always_comb begin
    m_cbe = 4'b0000;
    if (drive_bus && !m_addr_n) begin
      if (wr_q)                                       m_cbe = 4'b0111;
      else if (USE_MRM && (remaining > LEN_W'(1)))    m_cbe = 4'b1100;
      else                                            m_cbe = 4'b0110;
    end
  end

  assign adio_in = (drive_bus && !m_addr_n)        ? cur_addr :
                   (drive_bus && m_data && wr_q)   ? wr_mem[wr_rp] : 'z;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      wr_wp    <= '0;
      wr_rp    <= '0;
      wr_count <= '0;
      rd_wp    <= '0;
      rd_rp    <= '0;
      rd_count <= '0;
    end else begin
      if (wr_push) wr_wp <= wr_wp + AW'(1);
      if (wr_pop)  wr_rp <= wr_rp + AW'(1);
      wr_count <= wr_count + CW'(wr_push) - CW'(wr_pop);
      if (rd_push) rd_wp <= rd_wp + AW'(1);
      if (rd_pop)  rd_rp <= rd_rp + AW'(1);
      rd_count <= rd_count + CW'(rd_push) - CW'(rd_pop);
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_push) wr_mem[wr_wp] <= wr_data;
    if (rd_push) rd_mem[rd_wp] <= adio_out;
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      rtry_cnt  <= '0;
      wr_q      <= 1'b0;
      got_beat  <= 1'b0;
      m_dataq   <= 1'b0;
      fatal     <= 1'b0;
      request   <= 1'b0;
      complete  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      dead      <= 1'b0;
      m_ready   <= 1'b0;
    end else begin
      m_ready <= 1'b1;
      m_dataq <= m_data;
      request <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      if (!m_addr_n)   fatal <= 1'b0;
      else if (m_data) fatal <= csr[39] | csr[38];

      if (beat) begin
        remaining <= remaining - LEN_W'(1);
        cur_addr  <= cur_addr + 32'd4;
        got_beat  <= 1'b1;
        rtry_cnt  <= '0;
      end

      unique case (state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            state     <= S_REQ;
            request   <= 1'b1;
            cur_addr  <= {cmd_addr[31:2], 2'b00};
            remaining <= eff_len;
            wr_q      <= cmd_write;
            rtry_cnt  <= '0;
            got_beat  <= 1'b0;
            complete  <= (eff_len == LEN_W'(1));
          end
        end
        S_REQ: begin
          state    <= S_XFER;
          got_beat <= 1'b0;
        end
        S_XFER: begin
          if (m_data_fell) begin
            complete <= 1'b0;
            if (fatal) begin
              state <= S_DEAD;
              dead  <= 1'b1;
              done  <= 1'b1;
              err   <= 1'b1;
            end else if (remaining == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_RTY;
            end
          end else if (beat) begin
            // complete leads the data: high during the cycle the final beat is pending
            complete <= (remaining <= LEN_W'(2));
          end
        end
        S_RTY: begin
          if (!got_beat && (rtry_cnt == RW'(RETRY_MAX))) begin
            state <= S_ABORT;
            done  <= 1'b1;
            err   <= 1'b1;
          end else begin
            if (!got_beat) rtry_cnt <= rtry_cnt + RW'(1);
            state    <= S_REQ;
            request  <= 1'b1;
            complete <= (remaining == LEN_W'(1));
          end
        end
        S_DONE:  state <= S_IDLE;
        S_ABORT: state <= S_IDLE;
        S_DEAD:  state <= S_DEAD;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
